// File: rtl/lc3b_fetch_line_buffer_pkg.sv
// Shared types for the LC-3b fetch line buffer: bus/word types, line tag,
// fetch FSM states and line geometry.
package lc3b_fetch_line_buffer_pkg;

   typedef logic [15:0]  lc3b_word;
   typedef logic [127:0] lc3b_datbus;
   typedef logic [11:0]  lc3b_line_tag;

   typedef enum bit {if_idle, if_miss} lc3b_if_state;

   // A 128-bit line holds eight 16-bit instruction words.
   localparam int LINE_WORDS = 8;

endpackage

// File: rtl/lc3b_fetch_line_buffer_word_sel.sv
// Combinational word selector: picks one 16-bit word out of a 128-bit line.
// Word i occupies bits [16*i+15:16*i].
module lc3b_line_word_sel
   import lc3b_fetch_line_buffer_pkg::*;
(
   input  lc3b_datbus                      line,
   input  logic [$clog2(LINE_WORDS)-1:0]   index,
   output lc3b_word                        word
);

   // Index scaled by 16 selects the word's starting bit.
   always_comb begin
      word = line[{index, 4'b0000} +: 16];
   end

endmodule

// File: rtl/lc3b_fetch_line_buffer.sv
// LC-3b fetch stage with a one-entry line buffer.
// Holds the most recent I-cache line, streams one instruction per cycle into a
// registered IF/ID output under decode stall, and refills the buffer through a
// two-state request FSM. A redirect reloads the PC but never aborts an
// outstanding line request; the fill still lands and hit is re-evaluated.
module lc3b_fetch_line_buffer
   import lc3b_fetch_line_buffer_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000
)
(
   input  logic          clk,
   input  logic          rst,
   output logic          icache_read,
   output logic [15:0]   icache_address,
   input  logic [127:0]  icache_rdata,
   input  logic          icache_resp,
   input  logic          redirect,
   input  logic [15:0]   redirect_pc,
   input  logic          stall,
   output logic          if_valid,
   output logic [15:0]   if_instr,
   output logic [15:0]   if_pc,
   output logic [15:0]   if_pc_plus2
);

   localparam logic [15:0] RESET_PC_ALIGNED = RESET_PC & 16'hFFFE;

   logic [15:0]   pc_r;
   lc3b_datbus    line_buf_r;
   lc3b_line_tag  line_tag_r;
   logic          line_valid_r;
   lc3b_line_tag  req_tag_r;
   lc3b_if_state  state_r;

   logic          hit_s;
   logic          advance_s;
   lc3b_word      word_s;

   lc3b_line_word_sel u_word_sel (
      .line  (line_buf_r),
      .index (pc_r[3:1]),
      .word  (word_s)
   );

   // Hit against the buffered line and IF/ID acceptance.
   always_comb begin
      hit_s     = line_valid_r && (line_tag_r == pc_r[15:4]);
      advance_s = !if_valid || !stall;
   end

   // The request interface comes straight from the FSM and request-tag flops.
   assign icache_read    = (state_r == if_miss);
   assign icache_address = {req_tag_r, 4'b0000};

   // PC and IF/ID register: reset, then redirect, then normal streaming.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_r        <= RESET_PC_ALIGNED;
         if_valid    <= 1'b0;
         if_instr    <= 16'h0000;
         if_pc       <= 16'h0000;
         if_pc_plus2 <= 16'h0000;
      end else if (redirect) begin
         // Flush: drop the held instruction even when decode is stalled.
         pc_r     <= redirect_pc & 16'hFFFE;
         if_valid <= 1'b0;
      end else if (advance_s) begin
         if (hit_s) begin
            if_instr    <= word_s;
            if_pc       <= pc_r;
            if_pc_plus2 <= pc_r + 16'd2;
            if_valid    <= 1'b1;
            pc_r        <= pc_r + 16'd2;
         end else begin
            if_valid    <= 1'b0;
         end
      end
   end

   // Line request FSM and line buffer fill.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= if_idle;
         req_tag_r    <= 12'h000;
         line_buf_r   <= 128'h0;
         line_tag_r   <= 12'h000;
         line_valid_r <= 1'b0;
      end else begin
         case (state_r)
            if_idle: begin
               // Misses launch even while decode is stalled; responses in IDLE are dropped.
               if (!hit_s && !redirect) begin
                  req_tag_r <= pc_r[15:4];
                  state_r   <= if_miss;
               end
            end
            if_miss: begin
               if (icache_resp) begin
                  line_buf_r   <= icache_rdata;
                  line_tag_r   <= req_tag_r;
                  line_valid_r <= 1'b1;
                  state_r      <= if_idle;
               end
            end
            default: begin
               state_r <= if_idle;
            end
         endcase
      end
   end

endmodule
